// File: rtl/vga_capture.sv
// Purpose : VGA receive end; locks to hsync/vsync timing and turns the RGB stream into a pixel write stream.
// Latency : fixed 3 clocks from pins to pix_* (two input register stages, one output register stage).
// Backpressure: none; the stream runs at pixel-clock rate and the sink must accept every pix_valid.
//
// Ports:
//   clk, clr                 pixel clock, synchronous active-high reset
//   hsync, vsync             active-low syncs from the link
//   red, green, blue         3-bit colour samples
//   pix_valid/x/y/data       pixel write stream for the WIDTH x DEPTH active region
//   frame_start, frame_done  one-cycle pulses with pixel (0,0) and (WIDTH-1,DEPTH-1)
//   sync_err                 one-cycle pulse per timing violation
//   locked                   high whenever the capture FSM is out of SEEK
module vga_capture #(
    parameter int WIDTH = 640,
    parameter int DEPTH = 480,
    parameter int H_BP  = 48,
    parameter int V_BP  = 33,
    localparam int XW   = $clog2(WIDTH),
    localparam int YW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          hsync,
    input  logic          vsync,
    input  logic [2:0]    red,
    input  logic [2:0]    green,
    input  logic [2:0]    blue,
    output logic          pix_valid,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [8:0]    pix_data,
    output logic          frame_start,
    output logic          frame_done,
    output logic          sync_err,
    output logic          locked
);

    typedef enum logic [1:0] {SEEK, VBP, ACTIVE, TAIL} state_t;

    localparam logic [11:0] CNT_MAX = 12'hFFF;
    localparam logic [11:0] H_LO    = 12'(H_BP);
    localparam logic [11:0] H_HI    = 12'(H_BP + WIDTH);
    localparam logic [11:0] H_LAST  = 12'(H_BP + WIDTH - 1);
    localparam logic [11:0] V_LO    = 12'(V_BP);
    localparam logic [11:0] V_HI    = 12'(V_BP + DEPTH);

    state_t        state, state_nx;
    logic          s_hs, s_vs, s_hs_d, s_vs_d;
    logic [8:0]    s_rgb, s_rgb_d;
    logic [11:0]   hcnt, hcnt_nx;
    logic [11:0]   vline, vline_nx;
    logic          hs_end, vs_end;
    logic          in_win, line_act, last_px;
    logic          emit, done, err;
    logic [XW-1:0] x_nx;
    logic [YW-1:0] y_nx;

    always_comb begin
        hs_end   = s_hs & ~s_hs_d;
        vs_end   = s_vs & ~s_vs_d;

        // hcnt_nx/vline_nx describe the cycle whose pixel sits in s_rgb_d;
        // a sync edge restarts the count in the very cycle it is seen.
        hcnt_nx  = (hcnt == CNT_MAX) ? hcnt : hcnt + 12'd1;
        if (hs_end)
            hcnt_nx = '0;
        vline_nx = vline;
        if (vs_end)
            vline_nx = '0;
        else if (hs_end && vline != CNT_MAX)
            vline_nx = vline + 12'd1;

        in_win   = (hcnt_nx >= H_LO) && (hcnt_nx < H_HI) &&
                   (vline_nx >= V_LO) && (vline_nx < V_HI);
        x_nx     = XW'(hcnt_nx - H_LO);
        y_nx     = YW'(vline_nx - V_LO);
        last_px  = (x_nx == XW'(WIDTH - 1)) && (y_nx == YW'(DEPTH - 1));
        // line_act refers to the line that an hs_end is closing
        line_act = (vline >= V_LO) && (vline < V_HI);

        state_nx = state;
        emit     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        unique case (state)
            SEEK: begin
                if (vs_end)
                    state_nx = VBP;
            end
            VBP: begin
                if (!vs_end && hs_end && vline_nx == V_LO)
                    state_nx = ACTIVE;
            end
            ACTIVE: begin
                if (vs_end) begin
                    // frame cut short: restart timing without frame_done
                    err      = 1'b1;
                    state_nx = VBP;
                end else begin
                    emit = in_win;
                    if (hs_end && line_act && hcnt < H_LAST)
                        err = 1'b1;
                    if (in_win && last_px) begin
                        done     = 1'b1;
                        state_nx = TAIL;
                    end
                end
            end
            TAIL: begin
                if (vs_end)
                    state_nx = VBP;
            end
            default: state_nx = SEEK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr)
            state <= SEEK;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            // syncs reset to their idle level so release cannot fake an edge
            s_hs        <= 1'b1;
            s_vs        <= 1'b1;
            s_hs_d      <= 1'b1;
            s_vs_d      <= 1'b1;
            s_rgb       <= '0;
            s_rgb_d     <= '0;
            hcnt        <= '0;
            vline       <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_data    <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            sync_err    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            s_hs        <= hsync;
            s_vs        <= vsync;
            s_rgb       <= {red, green, blue};
            s_hs_d      <= s_hs;
            s_vs_d      <= s_vs;
            s_rgb_d     <= s_rgb;
            hcnt        <= hcnt_nx;
            vline       <= vline_nx;
            pix_valid   <= emit;
            if (emit) begin
                pix_x    <= x_nx;
                pix_y    <= y_nx;
                pix_data <= s_rgb_d;
            end
            frame_start <= emit && (x_nx == '0) && (y_nx == '0);
            frame_done  <= done;
            sync_err    <= err;
            locked      <= (state_nx != SEEK);
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Purpose : self-checking bench for vga_capture with a small 8x4 frame geometry.
// Latency : each expected pixel carries the cycle it must appear in (drive cycle + 3).
// Backpressure: none; the bench drives a free-running sync/RGB stream.
module tb_vga_capture;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int HB = 3;
    localparam int VB = 2;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic [2:0] red = '0, green = '0, blue = '0;
    logic       pix_valid;
    logic [2:0] pix_x;
    logic [1:0] pix_y;
    logic [8:0] pix_data;
    logic       frame_start, frame_done, sync_err, locked;

    vga_capture #(.WIDTH(W), .DEPTH(D), .H_BP(HB), .V_BP(VB)) dut (
        .clk(clk), .clr(clr), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .frame_start(frame_start), .frame_done(frame_done),
        .sync_err(sync_err), .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         x;
        int         y;
        logic [8:0] dat;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0, miscompares = 0;
    int   cyc = 0;
    int   pv_cnt = 0, fs_cnt = 0, fd_cnt = 0, serr_cnt = 0;
    logic [2:0] hx = '0;
    logic [1:0] hy = '0;
    logic [8:0] hd = '0;

    // Output monitor: pops the scoreboard on every pix_valid and checks
    // that idle cycles hold the last pixel fields with no stray pulses.
    always @(posedge clk) begin : mon
        exp_t e;
        logic clr_edge;
        logic efs, efd;
        cyc = cyc + 1;
        clr_edge = clr;
        #1;
        if (clr_edge) begin
            hx = '0; hy = '0; hd = '0;
        end
        if (sync_err)    serr_cnt++;
        if (frame_done)  fd_cnt++;
        if (frame_start) fs_cnt++;
        if (pix_valid === 1'b1) begin
            pv_cnt++;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL pixel_unexpected cyc=%0d got x=%0d y=%0d data=%h, required no pixel",
                         cyc, pix_x, pix_y, pix_data);
            end else begin
                e   = sb.pop_front();
                efs = (e.x == 0) && (e.y == 0);
                efd = (e.x == W - 1) && (e.y == D - 1);
                if (int'(pix_x) !== e.x || int'(pix_y) !== e.y || pix_data !== e.dat ||
                    frame_start !== efs || frame_done !== efd || cyc !== e.cyc) begin
                    miscompares++;
                    $display("FAIL pixel got x=%0d y=%0d data=%h fs=%b fd=%b cyc=%0d, required x=%0d y=%0d data=%h fs=%b fd=%b cyc=%0d",
                             pix_x, pix_y, pix_data, frame_start, frame_done, cyc,
                             e.x, e.y, e.dat, efs, efd, e.cyc);
                end
            end
            hx = pix_x; hy = pix_y; hd = pix_data;
        end else begin
            vectors++;
            if ({pix_valid, pix_x, pix_y, pix_data, frame_start, frame_done} !== {1'b0, hx, hy, hd, 2'b00}) begin
                miscompares++;
                $display("FAIL idle_hold cyc=%0d got x=%0d y=%0d data=%h fs=%b fd=%b, required x=%0d y=%0d data=%h fs=0 fd=0",
                         cyc, pix_x, pix_y, pix_data, frame_start, frame_done, hx, hy, hd);
            end
        end
    end

    // One line: hsync low for cycles 0..1; DUT hcnt=0 aligns with cycle 1,
    // so active pixel x sits on cycle x+4. Non-active cycles carry zero data.
    task automatic send_line(input logic vs, input int y, input bit act, input bit exp_en, input int len);
        logic [8:0] d;
        bit         pix;
        int         cx;
        for (int c = 0; c < len; c++) begin
            cx  = c - 4;
            pix = act && (c >= 4) && (c < 12);
            d   = pix ? {y[2:0], cx[2:0], 3'b000} : 9'd0;
            @(negedge clk);
            hsync = (c >= 2);
            vsync = vs;
            {red, green, blue} = d;
            if (pix && exp_en)
                sb.push_back('{cx, y, d, cyc + 3});
        end
    endtask

    // Frame of 8 lines: 0 = vsync low, 1 = back porch, 2..5 = y 0..3, 6..7 = front porch.
    task automatic send_frame(input int first, input int last, input bit exp_en,
                              input int trunc_y, input int early_y);
        int   y;
        bit   act;
        logic vs;
        for (int l = first; l <= last; l++) begin
            y   = l - 2;
            act = (l >= 2) && (l <= 5);
            vs  = !((l == 0) || (act && y == early_y));
            if (act && y == trunc_y) begin
                // Line cut to 7 cycles: hsync drops where x=3 would be; that
                // cycle (zero data, next line's cycle 0) is still x=3 of this line.
                send_line(vs, y, 1'b1, exp_en, 7);
                if (exp_en)
                    sb.push_back('{3, y, 9'd0, cyc + 4});
            end else begin
                send_line(vs, y, act, exp_en, 16);
            end
        end
    endtask

    task automatic check_sb_empty(input string name);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s_pending got %0d outstanding pixels, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        clr = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({pix_valid, pix_x, pix_y, pix_data, frame_start, frame_done, sync_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%b x=%0d y=%0d d=%h fs=%b fd=%b se=%b, required all 0",
                     pix_valid, pix_x, pix_y, pix_data, frame_start, frame_done, sync_err);
        end
        vectors++;
        if (locked !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_locked got %b, required 0", locked);
        end
        clr = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_clean_frame;
        int pv0 = pv_cnt, fs0 = fs_cnt, fd0 = fd_cnt, se0 = serr_cnt;
        send_frame(0, 7, 1'b1, -1, -1);
        vectors++;
        if (pv_cnt - pv0 !== 32) begin miscompares++; $display("FAIL clean_pixels got %0d, required 32", pv_cnt - pv0); end
        vectors++;
        if (fs_cnt - fs0 !== 1) begin miscompares++; $display("FAIL clean_frame_start got %0d, required 1", fs_cnt - fs0); end
        vectors++;
        if (fd_cnt - fd0 !== 1) begin miscompares++; $display("FAIL clean_frame_done got %0d, required 1", fd_cnt - fd0); end
        vectors++;
        if (serr_cnt - se0 !== 0) begin miscompares++; $display("FAIL clean_sync_err got %0d, required 0", serr_cnt - se0); end
        check_sb_empty("clean");
    endtask

    task automatic test_midframe_start;
        int pv0;
        clr = 1'b1;
        send_frame(0, 1, 1'b0, -1, -1);
        clr = 1'b0;
        pv0 = pv_cnt;
        send_frame(2, 7, 1'b0, -1, -1);
        vectors++;
        if (pv_cnt - pv0 !== 0) begin miscompares++; $display("FAIL midframe_no_pixels got %0d, required 0", pv_cnt - pv0); end
        send_frame(0, 0, 1'b1, -1, -1);
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("FAIL midframe_locked_before got %b, required 0", locked); end
        send_frame(1, 1, 1'b1, -1, -1);
        vectors++;
        if (locked !== 1'b1) begin miscompares++; $display("FAIL midframe_locked_after got %b, required 1", locked); end
        pv0 = pv_cnt;
        send_frame(2, 7, 1'b1, -1, -1);
        vectors++;
        if (pv_cnt - pv0 !== 32) begin miscompares++; $display("FAIL midframe_pixels got %0d, required 32", pv_cnt - pv0); end
        check_sb_empty("midframe");
    endtask

    task automatic test_back_to_back;
        int pv0 = pv_cnt, fd0 = fd_cnt, se0 = serr_cnt;
        send_frame(0, 7, 1'b1, -1, -1);
        send_frame(0, 7, 1'b1, -1, -1);
        vectors++;
        if (pv_cnt - pv0 !== 64) begin miscompares++; $display("FAIL b2b_pixels got %0d, required 64", pv_cnt - pv0); end
        vectors++;
        if (fd_cnt - fd0 !== 2) begin miscompares++; $display("FAIL b2b_frame_done got %0d, required 2", fd_cnt - fd0); end
        vectors++;
        if (serr_cnt - se0 !== 0) begin miscompares++; $display("FAIL b2b_sync_err got %0d, required 0", serr_cnt - se0); end
        check_sb_empty("b2b");
    endtask

    task automatic test_truncated_line;
        int pv0 = pv_cnt, fd0 = fd_cnt, se0 = serr_cnt;
        send_frame(0, 7, 1'b1, 1, -1);
        vectors++;
        if (pv_cnt - pv0 !== 28) begin miscompares++; $display("FAIL trunc_pixels got %0d, required 28", pv_cnt - pv0); end
        vectors++;
        if (serr_cnt - se0 !== 1) begin miscompares++; $display("FAIL trunc_sync_err got %0d, required 1", serr_cnt - se0); end
        vectors++;
        if (fd_cnt - fd0 !== 1) begin miscompares++; $display("FAIL trunc_frame_done got %0d, required 1", fd_cnt - fd0); end
        check_sb_empty("trunc");
    endtask

    task automatic test_early_vsync;
        int pv0 = pv_cnt, fd0 = fd_cnt, se0 = serr_cnt;
        send_frame(0, 4, 1'b1, -1, 2);
        send_frame(1, 1, 1'b1, -1, -1);
        vectors++;
        if (serr_cnt - se0 !== 1) begin miscompares++; $display("FAIL early_sync_err got %0d, required 1", serr_cnt - se0); end
        vectors++;
        if (fd_cnt - fd0 !== 0) begin miscompares++; $display("FAIL early_frame_done got %0d, required 0", fd_cnt - fd0); end
        vectors++;
        if (pv_cnt - pv0 !== 24) begin miscompares++; $display("FAIL early_pixels got %0d, required 24", pv_cnt - pv0); end
        send_frame(2, 7, 1'b1, -1, -1);
        vectors++;
        if (fd_cnt - fd0 !== 1) begin miscompares++; $display("FAIL early_next_frame_done got %0d, required 1", fd_cnt - fd0); end
        vectors++;
        if (pv_cnt - pv0 !== 56) begin miscompares++; $display("FAIL early_next_pixels got %0d, required 56", pv_cnt - pv0); end
        vectors++;
        if (serr_cnt - se0 !== 1) begin miscompares++; $display("FAIL early_next_sync_err got %0d, required 1", serr_cnt - se0); end
        check_sb_empty("early");
    endtask

    task automatic test_clr_pulse;
        int         pv0 = pv_cnt, fd0 = fd_cnt, se0 = serr_cnt;
        logic [8:0] d;
        bit         pix;
        int         cx;
        send_frame(0, 2, 1'b1, -1, -1);
        // Line y=1 with clr high for exactly the cycle that carries pixel (4,1);
        // only x=0,1 leave the pipeline before the reset edge.
        for (int c = 0; c < 16; c++) begin
            cx  = c - 4;
            pix = (c >= 4) && (c < 12);
            d   = pix ? {3'd1, cx[2:0], 3'b000} : 9'd0;
            @(negedge clk);
            if (c == 9) begin
                vectors++;
                if ({pix_valid, pix_x, pix_y, pix_data, frame_start, frame_done, sync_err, locked} !== '0) begin
                    miscompares++;
                    $display("FAIL clr_pulse_outputs got v=%b x=%0d y=%0d d=%h fs=%b fd=%b se=%b lk=%b, required all 0",
                             pix_valid, pix_x, pix_y, pix_data, frame_start, frame_done, sync_err, locked);
                end
            end
            hsync = (c >= 2);
            vsync = 1'b1;
            {red, green, blue} = d;
            clr = (c == 8);
            if (pix && c < 6)
                sb.push_back('{cx, 1, d, cyc + 3});
        end
        send_frame(4, 7, 1'b0, -1, -1);
        vectors++;
        if (pv_cnt - pv0 !== 10) begin miscompares++; $display("FAIL clr_pulse_pixels got %0d, required 10", pv_cnt - pv0); end
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("FAIL clr_pulse_locked got %b, required 0", locked); end
        send_frame(0, 7, 1'b1, -1, -1);
        vectors++;
        if (fd_cnt - fd0 !== 1) begin miscompares++; $display("FAIL clr_pulse_frame_done got %0d, required 1", fd_cnt - fd0); end
        vectors++;
        if (pv_cnt - pv0 !== 42) begin miscompares++; $display("FAIL clr_pulse_recapture got %0d, required 42", pv_cnt - pv0); end
        vectors++;
        if (serr_cnt - se0 !== 0) begin miscompares++; $display("FAIL clr_pulse_sync_err got %0d, required 0", serr_cnt - se0); end
        check_sb_empty("clr_pulse");
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_midframe_start();
        test_back_to_back();
        test_truncated_line();
        test_early_vsync();
        test_clr_pulse();
        repeat (8) @(negedge clk);
        check_sb_empty("final");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive end of the VGA link: samples an incoming hsync/vsync/RGB stream on the pixel clock.
- Locks to frame timing and recovers pixel coordinates.
- Emits a pixel write stream (valid/x/y/data) covering the WIDTH x DEPTH active region.
- Used to capture a rendered or test frame back into the image path for sobel input or loopback checking of the vga generator.

Parameters:
- WIDTH, 640, active pixels per line
- DEPTH, 480, active lines per frame
- H_BP, 48, pixel clocks from the hsync-end edge cycle (hcnt=0) to the first active pixel
- V_BP, 33, hsync-end edges after the vsync-end edge before the first active line

Ports:
- clk  in  1  pixel clock (25 MHz)
- clr  in  1  reset; synchronous, active-high
- hsync  in  1  horizontal sync, active-low
- vsync  in  1  vertical sync, active-low
- red  in  3  red sample
- green  in  3  green sample
- blue  in  3  blue sample
- pix_valid  out  1  active pixel present this cycle
- pix_x  out  $clog2(WIDTH)  pixel column
- pix_y  out  $clog2(DEPTH)  pixel row
- pix_data  out  9  {red,green,blue}
- frame_start  out  1  one-cycle pulse with pixel (0,0)
- frame_done  out  1  one-cycle pulse with pixel (WIDTH-1,DEPTH-1)
- sync_err  out  1  one-cycle pulse on timing violation
- locked  out  1  high when state is not SEEK

Behaviour:
Input sampling:
- All inputs are registered once (s_hs, s_vs, s_rgb).
- A second register holds s_hs_d and s_vs_d.
- hs_end = s_hs & ~s_hs_d; vs_end = s_vs & ~s_vs_d (rising edge = end of sync pulse).

Reset:
- clr=1 forces state SEEK.
- Sets s_hs, s_vs, s_hs_d, s_vs_d = 1 (no spurious edge).
- Clears hcnt, vline, and all outputs to 0.
- Reset mid-frame discards the partial frame; no frame_done is issued.

Counters:
- hcnt (12 bits, saturating): 0 on the hs_end cycle, else hcnt+1.
- vline: 0 on the vs_end cycle, including when hs_end occurs in the same cycle (vs_end wins); else +1 on each hs_end.
- A cycle is active when both hold:
  - H_BP <= hcnt < H_BP+WIDTH
  - V_BP <= vline < V_BP+DEPTH
- For an active cycle: x = hcnt-H_BP, y = vline-V_BP.

States:
- SEEK: outputs idle; on vs_end go to VBP.
- VBP: on the hs_end that makes vline = V_BP, go to ACTIVE.
- ACTIVE:
  - Active cycles produce pixels.
  - After pixel (WIDTH-1,DEPTH-1), go to TAIL.
  - vs_end while in ACTIVE: pulse sync_err, go to VBP, no frame_done.
- TAIL: ignore hs_end; on vs_end go to VBP.

Output timing:
- Outputs are registered.
- A pixel on the pins in cycle t appears on pix_* in cycle t+3 (two input stages + output stage).
- Latency is fixed and independent of position.
- pix_x, pix_y, pix_data hold their last value when pix_valid=0.

Pulses:
- frame_start is asserted with pix_valid for x=0, y=0 only.
- frame_done is asserted with pix_valid for x=WIDTH-1, y=DEPTH-1 only.

Short lines and overruns:
- hs_end in an active line with hcnt < H_BP+WIDTH-1 (line truncated): sync_err pulse.
  - Missing pixels are not emitted.
  - Line counting proceeds normally.
  - The frame still ends at y=DEPTH-1, x=WIDTH-1 if reached; otherwise ends on the next vs_end with sync_err.
- Long lines: hcnt beyond the active window emits nothing; saturation at 4095 is silent.
- sync_err pulses are one cycle; multiple errors give multiple pulses.

Test Plan (WIDTH=8, DEPTH=4, H_BP=3, V_BP=2; generator: hsync low 2 clocks, total line 16 clocks; vsync low 1 line; pixel data = {y[2:0],x[2:0],3'b0}):
1. Clean frame after reset:
   - 32 pix_valid pulses in raster order with correct x/y/data.
   - frame_start with (0,0); frame_done with (7,3).
   - First pixel exactly 3 clocks after it is driven.
   - sync_err never asserted.
2. Stream starts mid-frame (clr released at line 2):
   - No pix_valid until after the first vs_end; locked rises on that edge.
   - Next frame captured fully.
3. Back-to-back frames: two consecutive frames give 64 pixels and two frame_done pulses; TAIL ignores porch lines.
4. Truncated line: hsync asserted at hcnt=6 on line y=1:
   - Only x=0..3 emitted for y=1.
   - One sync_err pulse.
   - Lines y=2,3 intact; frame_done still issued.
5. Early vsync during y=2:
   - sync_err pulse; no frame_done.
   - Following frame captured completely.
6. clr pulsed for 1 cycle at pixel (4,1):
   - All outputs 0 the next cycle.
   - No further pix_valid until after the next vs_end; then normal capture.
